spi_dac_tx: RTL
===============

// Module: spi_dac_tx
// PURPOSE
//  Consumes the 12-bit word driven by the Nios PIO output port and streams it to an external
//  12-bit SPI DAC (MCP4921-style, 16-bit frame = 4 config bits + 12 data bits, SPI mode 0).
//  Sits directly downstream of the PIO: out_port -> data_in. Transfers start on an explicit
//  strobe or automatically when the PIO word changes. An LDAC pulse latches the DAC output.
// PARAMETERS
//  CLK_DIV    4        sclk half-period in clk cycles (>=1); sclk = clk/(2*CLK_DIV)
//  DATA_W     12       DAC data width; frame width FRAME_W = DATA_W + 4
//  CFG_BITS   4'b0111  frame bits [15:12]: A/B=0, BUF=1, GA_n=1, SHDN_n=1
//  AUTO_TRIG  1        1: start a frame when data_in != last_sent while idle
// PORTS
//  clk       in   1       system clock
//  reset_n   in   1       asynchronous, active-low reset
//  data_in   in   DATA_W  word to send (from PIO out_port)
//  start     in   1       single-cycle request; honoured only in IDLE
//  busy      out  1       frame in progress
//  done      out  1       1-cycle pulse at end of frame
//  sclk      out  1       SPI clock, idle low
//  mosi      out  1       SPI data, MSB first
//  cs_n      out  1       DAC chip select, active low
//  ldac_n    out  1       DAC latch strobe, active low
// BEHAVIOUR
//  - Reset (async, any state incl. mid-frame): state=IDLE, cs_n=1, ldac_n=1, sclk=0, mosi=0,
//    busy=0, done=0, shift reg=0, last_sent=0, counters=0. No frame resumes after reset.
//  - Trigger (IDLE only): start=1, or AUTO_TRIG && data_in!=last_sent. On the trigger edge
//    load shreg={CFG_BITS,data_in}, last_sent<=data_in. start while busy: ignored, not queued.
//  - States: IDLE -> SHIFT -> HOLD -> LATCH -> DONE -> IDLE.
//  - SHIFT: entered the cycle after trigger: cs_n=0, busy=1, sclk=0, mosi=shreg[15].
//    Every CLK_DIV cycles sclk toggles; mosi changes only on sclk falling (DAC samples rising).
//    16 rising edges; after the 16th falling edge -> HOLD. Duration 32*CLK_DIV cycles.
//  - HOLD: cs_n=0, sclk=0, CLK_DIV cycles (CS hold), then cs_n=1 -> LATCH.
//  - LATCH: cs_n=1, ldac_n=0 for CLK_DIV cycles -> DONE.
//  - DONE: 1 cycle, done=1, busy=0, ldac_n=1 -> IDLE.
//  - busy high for exactly 34*CLK_DIV cycles; cs_n low 33*CLK_DIV cycles.
//  - data_in changes during busy do not corrupt the frame; since last_sent holds the
//    captured word, AUTO_TRIG re-triggers from IDLE in the cycle after DONE if data_in differs.
//  - Trigger evaluated in the DONE cycle is ignored; earliest next cs_n fall is 2 cycles after done.
//  - Half-period counter width $clog2(CLK_DIV+1); bit counter 5 bits, no wrap beyond 16.
//  - All outputs registered; no combinational path from inputs to SPI pins.
// STRUCTURE
//  - Shared package/include spi_dac_pkg: state encoding (IDLE,SHIFT,HOLD,LATCH,DONE),
//    FRAME_W, default CFG_BITS constant.
//  - One sub-module: spi_dac_sclk_gen (half-period tick generator, enable/clear, CLK_DIV param).
//  - Top: FSM, 16-bit shift register, bit counter, last_sent register, output regs.
// TESTING
//  1 CLK_DIV=4, start with data_in=12'hA5C -> mosi frame 16'h7A5C MSB first sampled on sclk rise,
//    cs_n low 132 cycles, ldac_n low 4 cycles, done 1 cycle, busy 136 cycles.
//  2 AUTO_TRIG: data_in 0 -> 12'h123 (no start) -> frame 16'h7123; holding 12'h123 -> no further frame.
//  3 data_in 12'h111 -> 12'h222 mid-frame -> current frame 16'h7111 intact, then frame 16'h7222
//    with cs_n falling 2 cycles after done.
//  4 start pulses during busy -> exactly one frame; release after reset with data_in=0 -> no frame.
//  5 reset_n low at bit 7 of a frame -> same cycle cs_n=1, sclk=0, mosi=0, busy=0; no resumption.
//  6 CLK_DIV=1 -> sclk=clk/2, busy 34 cycles, frame 16'h7FFF for data_in=12'hFFF.

Source files
------------

// File: rtl/spi_dac_pkg.sv
// spi_dac_pkg: shared state encoding and frame constants for the SPI DAC transmitter
package spi_dac_pkg;
    typedef enum logic [2:0] {IDLE, SHIFT, HOLD, LATCH, DONE} state_t;
    localparam int FRAME_W = 16;
    localparam logic [3:0] CFG_DEFAULT = 4'b0111;
endpackage

// File: rtl/spi_dac_sclk_gen.sv
// spi_dac_sclk_gen: half-period tick generator, one tick every CLK_DIV enabled cycles
module spi_dac_sclk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick
);
    localparam int CW = $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
    logic [CW-1:0] r_cnt;
    assign o_tick = i_en && (r_cnt == LAST);
    // count enabled cycles, restarting on every tick so each state starts a fresh half-period
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) r_cnt <= '0;
        else if (i_clr || !i_en || o_tick) r_cnt <= '0;
        else r_cnt <= r_cnt + 1'b1;
endmodule

// File: rtl/spi_dac_tx.sv
// spi_dac_tx: streams a PIO word to an MCP4921-style SPI DAC (mode 0) and pulses LDAC
module spi_dac_tx
    import spi_dac_pkg::*;
#(
    parameter int         CLK_DIV   = 4,
    parameter int         DATA_W    = 12,
    parameter logic [3:0] CFG_BITS  = CFG_DEFAULT,
    parameter bit         AUTO_TRIG = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              sclk,
    output logic              mosi,
    output logic              cs_n,
    output logic              ldac_n
);
    localparam int FW = DATA_W + 4;
    state_t            r_state, w_next;
    logic [FW-1:0]     r_shreg;
    logic [DATA_W-1:0] r_last;
    logic [4:0]        r_bit;
    logic              w_tick, w_trig, w_fall;
    logic [FW-1:0]     w_frame;
    assign w_frame = {CFG_BITS, data_in};
    assign w_trig  = (r_state == IDLE) && (start || (AUTO_TRIG && (data_in != r_last)));
    assign w_fall  = (r_state == SHIFT) && w_tick && sclk;
    spi_dac_sclk_gen #(.CLK_DIV(CLK_DIV)) u_gen (
        .clk    (clk),
        .reset_n(reset_n),
        .i_en   (r_state inside {SHIFT, HOLD, LATCH}),
        .i_clr  (w_trig),
        .o_tick (w_tick)
    );
    // state register
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) r_state <= IDLE;
        else r_state <= w_next;
    // next-state: each timed phase advances on a half-period tick, SHIFT after the 16th fall
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_trig ? SHIFT : IDLE;
            SHIFT:   w_next = (w_fall && r_bit == 5'(FW - 1)) ? HOLD : SHIFT;
            HOLD:    w_next = w_tick ? LATCH : HOLD;
            LATCH:   w_next = w_tick ? DONE : LATCH;
            default: w_next = IDLE;
        endcase
    end
    // pins are registered from the next state so they line up with the state they describe
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            cs_n   <= 1'b1;
            ldac_n <= 1'b1;
            busy   <= 1'b0;
            done   <= 1'b0;
            sclk   <= 1'b0;
        end else begin
            cs_n   <= !(w_next inside {SHIFT, HOLD});
            ldac_n <= w_next != LATCH;
            busy   <= w_next inside {SHIFT, HOLD, LATCH};
            done   <= w_next == DONE;
            sclk   <= (w_next == SHIFT) && (r_state == SHIFT) && (sclk ^ w_tick);
        end
    // capture the word on trigger and advance mosi only on sclk falling edges
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            r_shreg <= '0;
            r_last  <= '0;
            r_bit   <= '0;
            mosi    <= 1'b0;
        end else if (w_trig) begin
            r_shreg <= w_frame;
            r_last  <= data_in;
            r_bit   <= '0;
            mosi    <= w_frame[FW-1];
        end else if (w_fall) begin
            r_shreg <= r_shreg << 1;
            r_bit   <= r_bit + 5'd1;
            mosi    <= r_shreg[FW-2];
        end
endmodule
